// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, branch condition codes, flag bit positions, fetch FSM states.
// Latency: n/a (constants, types and a pure decode function).
// Backpressure: n/a.
// Used by fetch_branch_unit, branch_cond_eval, decode and the ALU.
package isa_pkg;

    localparam int OPCODE_W = 4;
    localparam int INSTR_W  = 16;

    // Opcodes live in instr[15:12]; 0x0..0x7 are all flag-setting ALU ops.
    localparam logic [OPCODE_W-1:0] OP_ALU_LAST = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_JMP      = 4'hC;
    localparam logic [OPCODE_W-1:0] OP_BR       = 4'hD;
    localparam logic [OPCODE_W-1:0] OP_HALT     = 4'hF;

    // Encoding of an empty IR slot handed to decode.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    // Branch condition codes, instr[11:9] of a BR.
    localparam logic [2:0] COND_EQ = 3'd0;
    localparam logic [2:0] COND_NE = 3'd1;
    localparam logic [2:0] COND_LT = 3'd2;
    localparam logic [2:0] COND_GE = 3'd3;
    localparam logic [2:0] COND_CS = 3'd4;
    localparam logic [2:0] COND_CC = 3'd5;
    localparam logic [2:0] COND_MI = 3'd6;
    localparam logic [2:0] COND_AL = 3'd7;

    // Bit positions inside the 4-bit {N,Z,C,V} flags word.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        FETCH_RUN   = 2'd0,
        FETCH_STALL = 2'd1,
        FETCH_HALT  = 2'd2
    } fetch_state_e;

    // One-hot-ish classification of an opcode; at most one field is set.
    typedef struct packed {
        logic alu;
        logic br;
        logic jmp;
        logic halt;
    } op_class_t;

    function automatic op_class_t decode_op(input logic [OPCODE_W-1:0] opcode);
        op_class_t cls;
        cls.alu  = (opcode <= OP_ALU_LAST);
        cls.br   = (opcode == OP_BR);
        cls.jmp  = (opcode == OP_JMP);
        cls.halt = (opcode == OP_HALT);
        return cls;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates a 3-bit branch condition code against the {N,Z,C,V} flags word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output is valid whenever inputs are.
// Ports: cond (BR instr[11:9]), flags ({N,Z,C,V}), taken (condition holds).
module branch_cond_eval
    import isa_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign flag_n = flags[FLAG_N];
    assign flag_z = flags[FLAG_Z];
    assign flag_c = flags[FLAG_C];
    assign flag_v = flags[FLAG_V];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = flag_z;
            COND_NE: taken = !flag_z;
            COND_LT: taken = flag_n ^ flag_v;
            COND_GE: taken = !(flag_n ^ flag_v);
            COND_CS: taken = flag_c;
            COND_CC: taken = !flag_c;
            COND_MI: taken = flag_n;
            COND_AL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_branch_unit.sv
// Fetch control: drives PC enable/branch/jump, owns the flags register, stalls BR on in-flight flag writers.
// Latency: PC controls combinational in the fetch cycle; instruction register 1 cycle; BR stall = pending drain + 1.
// Backpressure: holds the PC (pc_en_po=0) while a BR waits for flags or after HALT; clk_en_pi=0 freezes all state.
// Ports: clk_pi/reset_pi (sync, active-high)/clk_en_pi; pc_pi, instr_pi from PC and ROM; alu_flags_pi/_we_pi from execute;
//        pc_en_po, branch_taken_po, branch_immediate_po, jump_taken_po, jump_immediate_po to the PC;
//        instr_po/instr_valid_po to decode; halted_po status.
module fetch_branch_unit
    import isa_pkg::*;
#(
    parameter int FLAG_CNT_W = 2
)
(
    input  logic                clk_pi,
    input  logic                reset_pi,
    input  logic                clk_en_pi,
    input  logic [15:0]         pc_pi,
    input  logic [INSTR_W-1:0]  instr_pi,
    input  logic [3:0]          alu_flags_pi,
    input  logic                alu_flags_we_pi,
    output logic                pc_en_po,
    output logic                branch_taken_po,
    output logic [5:0]          branch_immediate_po,
    output logic                jump_taken_po,
    output logic [11:0]         jump_immediate_po,
    output logic [INSTR_W-1:0]  instr_po,
    output logic                instr_valid_po,
    output logic                halted_po
);

    localparam logic [FLAG_CNT_W-1:0] PEND_ZERO = '0;
    localparam logic [FLAG_CNT_W-1:0] PEND_ONE  = FLAG_CNT_W'(1);
    localparam logic [FLAG_CNT_W-1:0] PEND_MAX  = {FLAG_CNT_W{1'b1}};

    fetch_state_e            state_q;
    fetch_state_e            state_d;
    logic [FLAG_CNT_W-1:0]   pending_q;
    logic [3:0]              flags_q;
    logic [INSTR_W-1:0]      instr_q;
    logic                    instr_vld_q;

    op_class_t               op_cls;
    logic                    pending_nz;
    logic                    br_blocked;
    logic                    cond_true;
    logic                    ir_load;
    logic                    pend_inc;
    logic                    pend_dec;

    // Control decisions only depend on the instruction, not on where it sits;
    // the PC value is accepted for interface symmetry with the PC block.
    logic                    pc_unused;
    assign pc_unused = ^pc_pi;

    // ------------------------------------------------------------------
    // Decode of the instruction currently presented by the ROM
    // ------------------------------------------------------------------
    assign op_cls     = decode_op(instr_pi[15:12]);
    assign pending_nz = (pending_q != PEND_ZERO);
    // A BR may not read the flags while any flag-setter is still in flight.
    assign br_blocked = op_cls.br && pending_nz;

    branch_cond_eval u_cond_eval (
        .cond  (instr_pi[11:9]),
        .flags (flags_q),
        .taken (cond_true)
    );

    assign branch_immediate_po = instr_pi[5:0];
    assign jump_immediate_po   = instr_pi[11:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            state_q <= FETCH_RUN;
        end else if (clk_en_pi) begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH_RUN: begin
                if (op_cls.halt) begin
                    state_d = FETCH_HALT;
                end else if (br_blocked) begin
                    state_d = FETCH_STALL;
                end
            end
            // Release one cycle after the counter reads zero, so the held BR
            // resolves in RUN against flags that include the last write-back.
            FETCH_STALL: begin
                if (!pending_nz) begin
                    state_d = FETCH_RUN;
                end
            end
            FETCH_HALT: begin
                state_d = FETCH_HALT;
            end
            default: begin
                state_d = FETCH_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs to the PC
    // ------------------------------------------------------------------
    always_comb begin
        pc_en_po        = 1'b0;
        branch_taken_po = 1'b0;
        jump_taken_po   = 1'b0;
        if (reset_pi) begin
            // Let the PC see its own reset edge; no redirects while resetting.
            pc_en_po = clk_en_pi;
        end else if (clk_en_pi && (state_q == FETCH_RUN) && !br_blocked && !op_cls.halt) begin
            pc_en_po        = 1'b1;
            branch_taken_po = op_cls.br && cond_true;
            jump_taken_po   = op_cls.jmp;
        end
    end

    assign halted_po = (state_q == FETCH_HALT);

    // ------------------------------------------------------------------
    // Instruction register, pending counter and flags register
    // ------------------------------------------------------------------
    // Control instructions are consumed here and never reach decode.
    assign ir_load  = pc_en_po && !reset_pi && !(op_cls.br || op_cls.jmp || op_cls.halt);
    assign pend_inc = ir_load && op_cls.alu;
    assign pend_dec = alu_flags_we_pi;

    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            instr_q     <= NOP_INSTR;
            instr_vld_q <= 1'b0;
            pending_q   <= PEND_ZERO;
            flags_q     <= 4'h0;
        end else if (clk_en_pi) begin
            instr_q     <= ir_load ? instr_pi : NOP_INSTR;
            instr_vld_q <= ir_load;

            // Write-back updates the flags even if the counter is already
            // zero (e.g. a writer issued before a reset of this block).
            if (alu_flags_we_pi) begin
                flags_q <= alu_flags_pi;
            end

            // Increment and decrement together cancel; both ends saturate.
            case ({pend_inc, pend_dec})
                2'b10: begin
                    if (pending_q != PEND_MAX) begin
                        pending_q <= pending_q + PEND_ONE;
                    end
                end
                2'b01: begin
                    if (pending_q != PEND_ZERO) begin
                        pending_q <= pending_q - PEND_ONE;
                    end
                end
                default: begin
                    pending_q <= pending_q;
                end
            endcase
        end
    end

    assign instr_po       = instr_q;
    assign instr_valid_po = instr_vld_q;

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Self-checking bench for fetch_branch_unit.
// Inputs change 1 time unit after the rising edge; outputs are sampled 4 units after it.
// IR expectations go through a queue: pushed when the cycle is driven, popped after the edge.
module tb_fetch_branch_unit;

    logic        clk_pi = 1'b0;
    logic        reset_pi = 1'b1;
    logic        clk_en_pi = 1'b1;
    logic [15:0] pc_pi = 16'h0000;
    logic [15:0] instr_pi = 16'h0000;
    logic [3:0]  alu_flags_pi = 4'h0;
    logic        alu_flags_we_pi = 1'b0;
    logic        pc_en_po;
    logic        branch_taken_po;
    logic [5:0]  branch_immediate_po;
    logic        jump_taken_po;
    logic [11:0] jump_immediate_po;
    logic [15:0] instr_po;
    logic        instr_valid_po;
    logic        halted_po;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [16:0] exp_q [$];
    logic [16:0] exp_ir;
    logic [16:0] got_ir;
    logic [15:0] b2b_tbl [0:7] = '{16'h1111, 16'h8123, 16'h9ABC, 16'h2000,
                                   16'hE001, 16'hA5A5, 16'hB000, 16'h7FFF};

    always #5 clk_pi = ~clk_pi;

    fetch_branch_unit #(.FLAG_CNT_W(2)) dut (
        .clk_pi              (clk_pi),
        .reset_pi            (reset_pi),
        .clk_en_pi           (clk_en_pi),
        .pc_pi               (pc_pi),
        .instr_pi            (instr_pi),
        .alu_flags_pi        (alu_flags_pi),
        .alu_flags_we_pi     (alu_flags_we_pi),
        .pc_en_po            (pc_en_po),
        .branch_taken_po     (branch_taken_po),
        .branch_immediate_po (branch_immediate_po),
        .jump_taken_po       (jump_taken_po),
        .jump_immediate_po   (jump_immediate_po),
        .instr_po            (instr_po),
        .instr_valid_po      (instr_valid_po),
        .halted_po           (halted_po)
    );

    task automatic tick();
        @(posedge clk_pi);
        #1;
    endtask

    task automatic drive(input logic [15:0] ins, input logic we, input logic [3:0] fl);
        instr_pi        = ins;
        alu_flags_we_pi = we;
        alu_flags_pi    = fl;
    endtask

    task automatic test_reset();
        reset_pi  = 1'b1;
        clk_en_pi = 1'b1;
        drive(16'hCFFE, 1'b1, 4'hF);
        #3;
        total_cnt++; if (pc_en_po !== 1'b1) $display("FAIL reset_pc_en got %0b exp 1", pc_en_po); else pass_cnt++;
        total_cnt++; if (jump_taken_po !== 1'b0) $display("FAIL reset_jump_taken got %0b exp 0", jump_taken_po); else pass_cnt++;
        tick();
        #3;
        total_cnt++; if ({instr_valid_po, instr_po} !== 17'h0) $display("FAIL reset_ir got %h exp 00000", {instr_valid_po, instr_po}); else pass_cnt++;
        total_cnt++; if (halted_po !== 1'b0) $display("FAIL reset_halted got %0b exp 0", halted_po); else pass_cnt++;
        reset_pi = 1'b0;
        drive(16'h1234, 1'b0, 4'h0);
        exp_q.push_back({1'b1, 16'h1234});
        tick();
        got_ir = {instr_valid_po, instr_po}; exp_ir = exp_q.pop_front();
        total_cnt++; if (got_ir !== exp_ir) $display("FAIL reset_first_ir got %h exp %h", got_ir, exp_ir); else pass_cnt++;
        // Retire the ALU op just loaded so later tests start with nothing pending.
        drive(16'h8000, 1'b1, 4'h0);
        exp_q.push_back({1'b1, 16'h8000});
        tick();
        got_ir = {instr_valid_po, instr_po}; exp_ir = exp_q.pop_front();
        total_cnt++; if (got_ir !== exp_ir) $display("FAIL reset_second_ir got %h exp %h", got_ir, exp_ir); else pass_cnt++;
    endtask

    task automatic test_jmp();
        pc_pi = 16'h0010;
        drive(16'hCFFE, 1'b0, 4'h0);
        exp_q.push_back({1'b0, 16'h0000});
        #3;
        total_cnt++; if (jump_taken_po !== 1'b1) $display("FAIL jmp_taken got %0b exp 1", jump_taken_po); else pass_cnt++;
        total_cnt++; if (jump_immediate_po !== 12'hFFE) $display("FAIL jmp_imm got %h exp ffe", jump_immediate_po); else pass_cnt++;
        total_cnt++; if (branch_taken_po !== 1'b0) $display("FAIL jmp_br_taken got %0b exp 0", branch_taken_po); else pass_cnt++;
        total_cnt++; if (pc_en_po !== 1'b1) $display("FAIL jmp_pc_en got %0b exp 1", pc_en_po); else pass_cnt++;
        tick();
        got_ir = {instr_valid_po, instr_po}; exp_ir = exp_q.pop_front();
        total_cnt++; if (got_ir !== exp_ir) $display("FAIL jmp_ir_nop got %h exp %h", got_ir, exp_ir); else pass_cnt++;
    endtask

    task automatic test_not_taken();
        pc_pi = 16'h0012;
        drive(16'hD005, 1'b0, 4'h0);
        #3;
        total_cnt++; if (branch_taken_po !== 1'b0) $display("FAIL nt_br_taken got %0b exp 0", branch_taken_po); else pass_cnt++;
        total_cnt++; if (pc_en_po !== 1'b1) $display("FAIL nt_pc_en got %0b exp 1", pc_en_po); else pass_cnt++;
        total_cnt++; if (branch_immediate_po !== 6'h05) $display("FAIL nt_br_imm got %h exp 05", branch_immediate_po); else pass_cnt++;
        tick();
        total_cnt++; if (instr_valid_po !== 1'b0) $display("FAIL nt_ir_valid got %0b exp 0", instr_valid_po); else pass_cnt++;
    endtask

    task automatic test_flag_stall();
        drive(16'h1000, 1'b0, 4'h0);
        #3;
        total_cnt++; if (pc_en_po !== 1'b1) $display("FAIL stall_alu_pc_en got %0b exp 1", pc_en_po); else pass_cnt++;
        tick();
        drive(16'hD002, 1'b0, 4'h0);
        #3;
        total_cnt++; if (pc_en_po !== 1'b0) $display("FAIL stall_br_pc_en got %0b exp 0", pc_en_po); else pass_cnt++;
        total_cnt++; if (branch_taken_po !== 1'b0) $display("FAIL stall_br_taken got %0b exp 0", branch_taken_po); else pass_cnt++;
        tick();
        #3;
        total_cnt++; if (pc_en_po !== 1'b0) $display("FAIL stall_wait_pc_en got %0b exp 0", pc_en_po); else pass_cnt++;
        tick();
        // A write-back offered while clock-enable is low must be ignored.
        clk_en_pi = 1'b0;
        drive(16'hD002, 1'b1, 4'b0100);
        #3;
        total_cnt++; if (pc_en_po !== 1'b0) $display("FAIL stall_clken_pc_en got %0b exp 0", pc_en_po); else pass_cnt++;
        total_cnt++; if (branch_taken_po !== 1'b0) $display("FAIL stall_clken_taken got %0b exp 0", branch_taken_po); else pass_cnt++;
        tick();
        clk_en_pi = 1'b1;
        drive(16'hD002, 1'b0, 4'h0);
        #3;
        total_cnt++; if (pc_en_po !== 1'b0) $display("FAIL stall_hold_pc_en got %0b exp 0", pc_en_po); else pass_cnt++;
        tick();
        drive(16'hD002, 1'b1, 4'b0100);
        #3;
        total_cnt++; if (pc_en_po !== 1'b0) $display("FAIL stall_wb_pc_en got %0b exp 0", pc_en_po); else pass_cnt++;
        tick();
        drive(16'hD002, 1'b0, 4'h0);
        #3;
        total_cnt++; if (pc_en_po !== 1'b0) $display("FAIL stall_release_pc_en got %0b exp 0", pc_en_po); else pass_cnt++;
        tick();
        #3;
        total_cnt++; if (pc_en_po !== 1'b1) $display("FAIL stall_resolve_pc_en got %0b exp 1", pc_en_po); else pass_cnt++;
        total_cnt++; if (branch_taken_po !== 1'b1) $display("FAIL stall_resolve_taken got %0b exp 1", branch_taken_po); else pass_cnt++;
        total_cnt++; if (branch_immediate_po !== 6'h02) $display("FAIL stall_resolve_imm got %h exp 02", branch_immediate_po); else pass_cnt++;
        tick();
    endtask

    task automatic test_counter();
        int zeros;
        bit done;
        // Write-back with nothing pending: count stays 0, flags still update.
        drive(16'h8000, 1'b1, 4'b0000);
        tick();
        drive(16'hD003, 1'b0, 4'h0);
        #3;
        total_cnt++; if (pc_en_po !== 1'b1) $display("FAIL cnt_zero_pc_en got %0b exp 1", pc_en_po); else pass_cnt++;
        total_cnt++; if (branch_taken_po !== 1'b0) $display("FAIL cnt_zero_eq_taken got %0b exp 0", branch_taken_po); else pass_cnt++;
        tick();
        drive(16'hD203, 1'b0, 4'h0);
        #3;
        total_cnt++; if (branch_taken_po !== 1'b1) $display("FAIL cnt_zero_ne_taken got %0b exp 1", branch_taken_po); else pass_cnt++;
        tick();
        // Load and write-back in the same cycle keep the count at 1.
        drive(16'h2000, 1'b0, 4'h0);
        tick();
        drive(16'h3000, 1'b1, 4'b0100);
        tick();
        drive(16'hD002, 1'b0, 4'h0);
        #3;
        total_cnt++; if (pc_en_po !== 1'b0) $display("FAIL cnt_simul_br_pc_en got %0b exp 0", pc_en_po); else pass_cnt++;
        tick();
        drive(16'hD002, 1'b1, 4'b0100);
        tick();
        drive(16'hD002, 1'b0, 4'h0);
        #3;
        total_cnt++; if (pc_en_po !== 1'b0) $display("FAIL cnt_simul_release_pc_en got %0b exp 0", pc_en_po); else pass_cnt++;
        tick();
        #3;
        total_cnt++; if (pc_en_po !== 1'b1) $display("FAIL cnt_simul_resolve_pc_en got %0b exp 1", pc_en_po); else pass_cnt++;
        tick();
        // Four writers into a 2-bit counter saturate at 3; three write-backs drain it.
        for (int i = 0; i < 4; i++) begin
            drive(16'h4000, 1'b0, 4'h0);
            tick();
        end
        drive(16'hD002, 1'b0, 4'b0100);
        zeros = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            alu_flags_we_pi = (i >= 1 && i <= 3);
            #3;
            if (pc_en_po === 1'b1) begin
                done = 1'b1;
                total_cnt++; if (branch_taken_po !== 1'b1) $display("FAIL cnt_sat_taken got %0b exp 1", branch_taken_po); else pass_cnt++;
            end else begin
                zeros++;
            end
            tick();
        end
        alu_flags_we_pi = 1'b0;
        total_cnt++; if (done !== 1'b1) $display("FAIL cnt_sat_timeout got %0b exp 1", done); else pass_cnt++;
        total_cnt++; if (zeros != 5) $display("FAIL cnt_sat_stall_len got %0d exp 5", zeros); else pass_cnt++;
    endtask

    task automatic test_halt_reset();
        // Reset in the middle of a stall clears state and pending.
        drive(16'h1000, 1'b0, 4'h0);
        tick();
        drive(16'hD000, 1'b0, 4'h0);
        tick();
        reset_pi = 1'b1;
        #3;
        total_cnt++; if (pc_en_po !== 1'b1) $display("FAIL rst_stall_pc_en got %0b exp 1", pc_en_po); else pass_cnt++;
        tick();
        reset_pi = 1'b0;
        #3;
        total_cnt++; if (pc_en_po !== 1'b1) $display("FAIL rst_stall_cleared_pc_en got %0b exp 1", pc_en_po); else pass_cnt++;
        total_cnt++; if (branch_taken_po !== 1'b0) $display("FAIL rst_stall_flags_taken got %0b exp 0", branch_taken_po); else pass_cnt++;
        tick();
        drive(16'hF000, 1'b0, 4'h0);
        #3;
        total_cnt++; if (pc_en_po !== 1'b0) $display("FAIL halt_op_pc_en got %0b exp 0", pc_en_po); else pass_cnt++;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive((i == 0) ? 16'h1000 : ((i == 1) ? 16'hC000 : 16'hD7FF), 1'b0, 4'h0);
            #3;
            total_cnt++; if (halted_po !== 1'b1) $display("FAIL halt_halted_%0d got %0b exp 1", i, halted_po); else pass_cnt++;
            total_cnt++; if ({pc_en_po, jump_taken_po, branch_taken_po} !== 3'b000) $display("FAIL halt_ctrl_%0d got %b exp 000", i, {pc_en_po, jump_taken_po, branch_taken_po}); else pass_cnt++;
            tick();
        end
        reset_pi = 1'b1;
        #3;
        total_cnt++; if (pc_en_po !== 1'b1) $display("FAIL halt_reset_pc_en got %0b exp 1", pc_en_po); else pass_cnt++;
        tick();
        reset_pi = 1'b0;
        drive(16'h8000, 1'b0, 4'h0);
        #3;
        total_cnt++; if (halted_po !== 1'b0) $display("FAIL halt_exit_halted got %0b exp 0", halted_po); else pass_cnt++;
        total_cnt++; if (pc_en_po !== 1'b1) $display("FAIL halt_exit_pc_en got %0b exp 1", pc_en_po); else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [16:0] last_exp;
        last_exp = {1'b1, 16'h8000};
        for (int i = 0; i < 8; i++) begin
            drive(b2b_tbl[i], (i % 2) == 1, 4'h0);
            clk_en_pi = (i != 4);
            // With clock-enable low the IR keeps whatever it held.
            if (i != 4) last_exp = {1'b1, b2b_tbl[i]};
            exp_q.push_back(last_exp);
            tick();
            got_ir = {instr_valid_po, instr_po}; exp_ir = exp_q.pop_front();
            total_cnt++; if (got_ir !== exp_ir) $display("FAIL b2b_ir_%0d got %h exp %h", i, got_ir, exp_ir); else pass_cnt++;
        end
        clk_en_pi = 1'b1;
        alu_flags_we_pi = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_jmp();
        test_not_taken();
        test_flag_stall();
        test_counter();
        test_halt_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
